imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer-side block for the single-cycle datapath's instruction memory.
- Accepts a byte stream (valid/ready): one length byte N, then 4*N program bytes.
- Assembles big-endian 32-bit words and writes them to consecutive byte addresses 0, 4, 8, ... on the same address space the core fetches with its 8-bit pc.
- Holds the core stopped (core_run=0) during loading and releases it only after the last word is written.

Parameters:
- DEPTH_WORDS, 64, maximum program length in words; must be at most 64 so that 4*DEPTH_WORDS-4 fits in 8 address bits.
- ADDR_W, 8, byte-address width; matches the pc width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load; sampled only in IDLE, DONE or ERROR.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  byte address of the word being written.
- mem_wdata  out  32  word being written.
- core_run  out  1  1 = datapath clock-enable/run; 0 = core held.
- done  out  1  load completed successfully.
- err  out  1  bad length byte received.
- words_loaded  out  7  count of words written in the current or most recent load.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; every output at 0, including mem_addr, mem_wdata, words_loaded and in_ready. Reset mid-load abandons the load; memory contents already written are not restored.
- Transfer rule: a byte is transferred on a rising edge when in_valid=1 and in_ready=1. in_data is don't-care otherwise.
- State IDLE: in_ready=0. On start -> LEN. Clear words_loaded, done and err.
- State LEN: in_ready=1. On transfer, latch N=in_data.
  - N=0 or N>DEPTH_WORDS -> ERROR.
  - Otherwise -> BYTES, with byte_cnt=0 and addr=0.
- State BYTES: in_ready=1. Each transfer shifts the byte into the assembly register; the first byte lands in [31:24] and the fourth in [7:0]. On the fourth byte -> WRITE.
- State WRITE: exactly one cycle; in_ready=0.
  - mem_we=1, mem_addr=addr, mem_wdata=assembled word.
  - On the edge ending WRITE: words_loaded+=1, addr+=4.
  - If words_loaded (after increment) equals N -> DONE; else -> BYTES.
- State DONE: done=1, core_run=1, in_ready=0. Both stay asserted until start or reset. start -> LEN with core_run=0, done=0 and words_loaded=0, all on the same edge.
- State ERROR: err=1, core_run=0, in_ready=0. Held until start (-> LEN, err cleared) or reset.
- start in LEN, BYTES or WRITE is ignored; a load cannot be restarted except by reset.
- Outputs are registered; mem_we asserts the cycle after the fourth byte's transfer edge.
- Minimum load latency: 1 (LEN) + 5*N cycles from the first LEN cycle to the first DONE cycle, with in_valid held high.
- in_valid gaps simply stall BYTES/LEN; no timeout.
- Address arithmetic: mem_addr is ADDR_W bits. With DEPTH_WORDS=64 the highest address is 252; the 8-bit wrap is unreachable.
- mem_addr and mem_wdata hold their last value outside WRITE.
- core_run is 0 in every state except DONE.

Decomposition:
- Shared package imem_pkg:
  - State enum: IDLE, LEN, BYTES, WRITE, DONE, ERROR.
  - Constants IMEM_ADDR_W=8 and IMEM_WORD_BYTES=4.
  - These constants are shared with the datapath's instruction memory.
- One sub-module: byte_packer, which shifts bytes in and flags a full word after 4 bytes. It is cleared on entry to BYTES from LEN.
- The FSM and counters remain in imem_loader.

Test Plan:
- Reset mid-BYTES after 2 bytes -> all outputs 0 immediately (asynchronously); state IDLE; no mem_we afterward.
- start, then stream 0x02, 0x20,0x08,0x00,0x05, 0x20,0x09,0x00,0x07, with in_valid held high:
  - mem_we pulses at addr 0 with 0x20080005, then at addr 4 with 0x20090007.
  - done=1 and core_run=1 eleven cycles after the first LEN cycle; words_loaded=2.
- Same program with in_valid deasserted 3 cycles between bytes -> identical writes and data; completion delayed by exactly the stall cycles.
- Length byte 0x00, and separately 0x41 (65) -> err=1, in_ready=0, no mem_we. A following start re-enters LEN with err=0.
- N=64 with 256 bytes -> last write at mem_addr=252; words_loaded=64; done=1.
- start pulsed during BYTES -> ignored, load completes normally. start in DONE -> core_run drops to 0 on that edge and a new LEN phase begins.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Brief    : Shared types and constants for the instruction-memory loader
//            and the datapath's instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Byte-address width; matches the core's program counter.
  localparam int IMEM_ADDR_W     = 8;
  // Bytes per instruction word; also the address stride between words.
  localparam int IMEM_WORD_BYTES = 4;

  // Loader state encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_BYTES = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } imem_state_e;

  // A program length is usable when it is non-zero and fits in memory.
  function automatic logic len_ok(input logic [7:0] n, input logic [7:0] max_words);
    return (n != 8'd0) && (n <= max_words);
  endfunction

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Brief    : Shifts stream bytes into a big-endian 32-bit word and flags the
//            push that completes a word (first byte ends up in [31:24]).
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_full
);

  // Only the three oldest bytes need storage; the fourth arrives with the push.
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  localparam logic [1:0] c_LAST_IDX = 2'(IMEM_WORD_BYTES - 1);

  // Word as it will look once the current byte is shifted in.
  assign o_word_next = {r_shift, i_byte};
  // Asserted on the push that delivers the final byte of a word.
  assign o_full      = i_push && (r_cnt == c_LAST_IDX);

  // Shift register and byte counter; the counter wraps to 0 after a full word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 24'd0;
      r_cnt   <= 2'd0;
    end else if (i_clear) begin
      r_shift <= 24'd0;
      r_cnt   <= 2'd0;
    end else if (i_push) begin
      r_shift <= o_word_next[23:0];
      r_cnt   <= r_cnt + 2'd1;
    end
  end

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Loads a length-prefixed byte stream into instruction memory as
//            big-endian words at byte addresses 0, 4, 8, ... and holds the
//            core stopped until the whole program has been written.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              done,
  output logic              err,
  output logic [6:0]        words_loaded
);

  localparam logic [7:0]        c_DEPTH  = 8'(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(IMEM_WORD_BYTES);

  imem_state_e       r_state;
  logic [6:0]        r_n;
  logic [ADDR_W-1:0] r_addr;
  logic [6:0]        r_words;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_core_run;
  logic              r_done;
  logic              r_err;

  logic              w_xfer;
  logic              w_push;
  logic              w_clear;
  logic              w_word_full;
  logic [31:0]       w_word_next;
  logic [6:0]        w_words_inc;

  // A byte moves only when both sides agree on the same edge.
  assign w_xfer      = in_valid && r_in_ready;
  assign w_push      = w_xfer && (r_state == S_BYTES);
  // The packer starts clean for every accepted program length.
  assign w_clear     = w_xfer && (r_state == S_LEN) && len_ok(in_data, c_DEPTH);
  assign w_words_inc = r_words + 7'd1;

  byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_byte      (in_data),
    .o_word_next (w_word_next),
    .o_full      (w_word_full)
  );

  // Load sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_n         <= 7'd0;
      r_addr      <= '0;
      r_words     <= 7'd0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_core_run  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Write strobe lasts exactly one cycle unless re-armed below.
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          // A new load always starts from a clean status, core held.
          if (start) begin
            r_state    <= S_LEN;
            r_in_ready <= 1'b1;
            r_core_run <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= 7'd0;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            r_n <= in_data[6:0];
            if (len_ok(in_data, c_DEPTH)) begin
              r_state <= S_BYTES;
              r_addr  <= '0;
            end else begin
              r_state    <= S_ERROR;
              r_err      <= 1'b1;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_BYTES: begin
          // The fourth byte completes the word; present it for one write cycle.
          if (w_word_full) begin
            r_state     <= S_WRITE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_word_next;
          end
        end
        S_WRITE: begin
          r_words <= w_words_inc;
          r_addr  <= r_addr + c_STRIDE;
          if (w_words_inc == r_n) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_core_run <= 1'b1;
          end else begin
            r_state    <= S_BYTES;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_core_run <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign core_run     = r_core_run;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule : imem_loader
`default_nettype wire
